// File: rtl/qpsk_rx_pkg.sv
// Shared types and constants for the QPSK receive frame controller.
// The CRC helper is only used when QPSK_RX_CRC_EN is defined.
package qpsk_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    HUNT,
    LEN,
    PAYLOAD
  } rx_state_t;

  localparam logic [7:0]  CRC8_POLY         = 8'h07;
  localparam int          SYMS_PER_BYTE     = 4;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h1ACF;

  // One byte through a CRC-8 (MSB first, no reflection, no final xor)
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/qpsk_rx_frame_ctrl_if.sv
// Valid/ready byte port between the frame controller and the packet consumer.
interface qpsk_rx_frame_ctrl_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/qpsk_sym_strobe.sv
// Decimator: counts valid demod samples and strobes the mid-symbol one.
// An sps of 0 behaves like 1, so every valid sample is taken.
module qpsk_sym_strobe #(
  parameter int SPS_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [SPS_W-1:0] sps,
  input  logic             symbol_valid,
  output logic             sym_stb
);

  logic [SPS_W-1:0] phase;
  logic [SPS_W-1:0] sps_eff;
  logic [SPS_W-1:0] half;

  assign sps_eff = (sps == '0) ? {{(SPS_W-1){1'b0}}, 1'b1} : sps;
  assign half    = sps_eff >> 1;

  // >= rather than == so a shrinking sps mid-run cannot strand the counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (symbol_valid) begin
      phase <= (phase >= sps_eff - 1'b1) ? '0 : phase + 1'b1;
    end
  end

  assign sym_stb = symbol_valid && (phase == half);

endmodule

// File: rtl/qpsk_rx_frame_ctrl.sv
// Receive sequencer: lock gating, sync-word hunt, length-prefixed payload to bytes.
// Define QPSK_RX_CRC_EN to check a trailing CRC-8 byte and add the crc_ok output.
module qpsk_rx_frame_ctrl
  import qpsk_rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int          SPS_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [SPS_W-1:0]       sps,
  input  logic [1:0]             symbol_in,
  input  logic                   symbol_valid,
  input  logic                   locked,
  qpsk_rx_frame_ctrl_if.master   byte_if,
  output logic [7:0]             frame_len,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
`ifdef QPSK_RX_CRC_EN
  ,
  output logic                   crc_ok
`endif
);

  rx_state_t   state;
  rx_state_t   state_nxt;
  logic [15:0] sync_sr;
  logic [15:0] sync_shift;
  logic [5:0]  sym_sr;
  logic [1:0]  sym_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  byte_asm;
  logic [7:0]  byte_data_q;
  logic        byte_valid_q;
  logic        sym_stb;
  logic        phase_clear;
  logic        byte_complete;
  logic        sync_clear;
  logic        sync_load;
  logic        sym_take;
  logic        sym_clear;
  logic        len_load;
  logic        pay_load;
  logic        start_set;
  logic        end_set;
  logic        err_set;

  assign phase_clear = (state == IDLE) || (state == WAIT_LOCK);

  qpsk_sym_strobe #(
    .SPS_W(SPS_W)
  ) u_sym_strobe (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (phase_clear),
    .sps          (sps),
    .symbol_valid (symbol_valid),
    .sym_stb      (sym_stb)
  );

  // Both compares look at the symbol arriving this cycle, not just stored history
  assign sync_shift    = {sync_sr[13:0], symbol_in};
  assign byte_asm      = {sym_sr, symbol_in};
  assign byte_complete = sym_stb && (sym_cnt == 2'(SYMS_PER_BYTE - 1));

  assign busy               = (state == LEN) || (state == PAYLOAD);
  assign byte_if.byte_data  = byte_data_q;
  assign byte_if.byte_valid = byte_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sync_clear = 1'b0;
    sync_load  = 1'b0;
    sym_take   = 1'b0;
    sym_clear  = 1'b0;
    len_load   = 1'b0;
    pay_load   = 1'b0;
    start_set  = 1'b0;
    end_set    = 1'b0;
    err_set    = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked) begin
            state_nxt  = HUNT;
            sync_clear = 1'b1;
          end
        end
        HUNT: begin
          if (!locked) begin
            state_nxt = WAIT_LOCK;
          end else if (sym_stb) begin
            sync_load = 1'b1;
            if (sync_shift == SYNC_WORD) begin
              state_nxt = LEN;
              start_set = 1'b1;
              sym_clear = 1'b1;
            end
          end
        end
        LEN: begin
          if (!locked) begin
            state_nxt = WAIT_LOCK;
            err_set   = 1'b1;
          end else if (sym_stb) begin
            sym_take = 1'b1;
            if (byte_complete) begin
              len_load = 1'b1;
              if (byte_asm == 8'd0) begin
                state_nxt  = HUNT;
                end_set    = 1'b1;
                sync_clear = 1'b1;
              end else begin
                state_nxt = PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (!locked) begin
            state_nxt = WAIT_LOCK;
            err_set   = 1'b1;
          end else if (sym_stb) begin
            sym_take = 1'b1;
            if (byte_complete) begin
              pay_load = 1'b1;
              if (byte_cnt == 8'd1) begin
                state_nxt  = HUNT;
                end_set    = 1'b1;
                sync_clear = 1'b1;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_sr     <= '0;
      sym_sr      <= '0;
      sym_cnt     <= '0;
      byte_cnt    <= '0;
      frame_len   <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_start <= start_set;
      frame_end   <= end_set;
      frame_err   <= err_set;
      if (sync_clear) begin
        sync_sr <= '0;
      end else if (sync_load) begin
        sync_sr <= sync_shift;
      end
      if (sym_clear) begin
        sym_cnt <= '0;
      end else if (sym_take) begin
        sym_cnt <= sym_cnt + 2'd1;
        sym_sr  <= byte_asm[5:0];
      end
      if (len_load) begin
        frame_len <= byte_asm;
        byte_cnt  <= byte_asm;
      end else if (pay_load) begin
        byte_cnt <= byte_cnt - 8'd1;
      end
    end
  end

  // A byte landing on an accepting handshake is not an overrun; only an unread one is
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      overrun      <= 1'b0;
    end else if (!enable) begin
      byte_valid_q <= 1'b0;
      overrun      <= 1'b0;
    end else if (pay_load) begin
      byte_data_q  <= byte_asm;
      byte_valid_q <= 1'b1;
      if (byte_valid_q && !byte_if.byte_ready) begin
        overrun <= 1'b1;
      end
    end else if (byte_valid_q && byte_if.byte_ready) begin
      byte_valid_q <= 1'b0;
    end
  end

`ifdef QPSK_RX_CRC_EN
  logic [7:0] crc_q;

  // The final payload byte is the received CRC, so it is compared, not accumulated
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q  <= '0;
      crc_ok <= 1'b0;
    end else begin
      crc_ok <= end_set && (pay_load ? (crc_q == byte_asm) : 1'b1);
      if (len_load) begin
        crc_q <= '0;
      end else if (pay_load && (byte_cnt != 8'd1)) begin
        crc_q <= crc8_update(crc_q, byte_asm);
      end
    end
  end
`endif

endmodule
